// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line of the 8N1 transmitter
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done_tick;
  logic                 tx;
  modport master(output tx_start, tx_data, input tx_ready, tx_busy, tx_done_tick, tx);
  modport slave(input tx_start, tx_data, output tx_ready, tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter with baud-tick generator and one-byte holding register
module uart_tx_unit #(
  parameter int CLK_DIV    = 41,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int OW = $clog2((OVERSAMPLE > STOP_TICKS ? OVERSAMPLE : STOP_TICKS) + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d, done_q, done_d;
  logic                 tick, bit_end, stop_end, accept, load;
  always_comb begin
    tick       = tick_cnt_q == TW'(CLK_DIV - 1);
    bit_end    = tick && os_cnt_q == OW'(OVERSAMPLE - 1);
    stop_end   = tick && os_cnt_q == OW'(STOP_TICKS - 1);
    accept     = bus.tx_start && !hold_full_q;
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = accept ? bus.tx_data : hold_q;
    hold_full_d = hold_full_q || accept;
    done_d     = 1'b0;
    load       = 1'b0;
    tick_cnt_d = (state_q == IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d   = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        os_cnt_d  = '0;
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = bit_cnt_q == BW'(DATA_BITS - 1) ? STOP : DATA;
      end
      default: if (stop_end) begin
        os_cnt_d = '0;
        done_d   = 1'b1;
        load     = hold_full_q;
        state_d  = hold_full_q ? START : IDLE;
      end
    endcase
    // accept and load never coincide: accept needs hold_full_q=0, load needs it set
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end
  assign bus.tx           = tx_q;
  assign bus.tx_ready     = ~hold_full_q;
  assign bus.tx_busy      = state_q != IDLE;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed stimulus with a byte scoreboard checked by a serial-line receiver model
module tb_uart_tx_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_if #(.DATA_BITS(8)) bus();
  uart_tx_unit #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .STOP_TICKS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int rst_cnt = 0;
  int run = 0;
  int last_run = 0;
  int dones = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) if (reset) rst_cnt++;
  always @(negedge clk) begin
    if (bus.tx_busy === 1'b1) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (bus.tx_done_tick === 1'b1) dones++;
  end
  // receiver model: samples each 64-cycle bit at its midpoint, frames aborted by reset are dropped
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0 && bus.tx === 1'b0) begin
      int r;
      logic [9:0] f;
      r = rst_cnt;
      f = '0;
      for (int k = 1; k <= 608; k++) begin
        @(negedge clk);
        if (k % 64 == 32) f[k/64] = bus.tx;
      end
      if (rst_cnt == r) begin
        check("start_bit", f[0], 0);
        check("stop_bit", f[9], 1);
        check("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check("rx_byte", f[8:1], sb.pop_front());
      end
    end
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", n < 20000, 1);
    bus.tx_data = b;
    bus.tx_start = 1'b1;
    sb.push_back(b);
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.tx_busy !== 1'b0 || sb.size() != 0) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 30000, 1);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int first, pulses, d0;
    logic low_seen;
    bus.tx_start = 1'b0;
    bus.tx_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done_tick}, 4'b1100);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_quiet", {bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done_tick}, 4'b1100);
    end
    send(8'hA5);
    check("capture_edge", {bus.tx, bus.tx_ready, bus.tx_busy}, 3'b100);
    @(negedge clk);
    check("start_edge", {bus.tx, bus.tx_ready, bus.tx_busy}, 3'b011);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (k == 63) check("start_len", bus.tx, 0);
      if (k == 64) check("a5_bit0", bus.tx, 1);
      if (bus.tx_done_tick === 1'b1) begin
        if (first == 0) first = k;
        pulses++;
      end
    end
    check("done_pos", first, 640);
    check("done_pulses", pulses, 1);
    check("busy_after_frame", bus.tx_busy, 0);
    check("busy_len_single", last_run, 640);
    wait_idle();
    d0 = dones;
    send(8'h3C);
    @(negedge clk);
    send(8'hC3);
    wait_idle();
    check("busy_len_b2b", last_run, 1280);
    check("done_count_b2b", dones - d0, 2);
    d0 = dones;
    send(8'h0F);
    @(negedge clk);
    send(8'hF0);
    check("held_ready", bus.tx_ready, 0);
    bus.tx_data = 8'hFF;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("ignored_ready", bus.tx_ready, 0);
    wait_idle();
    check("done_count_ignore", dones - d0, 2);
    send(8'h00);
    @(negedge clk);
    send(8'h77);
    repeat (298) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", {bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done_tick}, 4'b1100);
    sb.delete();
    reset = 1'b0;
    d0 = dones;
    low_seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) low_seen = 1'b1;
    end
    @(posedge clk);
    check("no_done_after_abort", dones - d0, 0);
    check("pending_dropped", low_seen, 0);
    @(negedge clk);
    send(8'h55);
    wait_idle();
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    send(8'hAA);
    wait_idle();
    check("loopback_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
